// File: rtl/connect4_move_input.sv
// Move-entry front end: synchronizes and debounces the drop button, latches the
// column switches on a press, validates the move and offers it with valid/ready.
module connect4_move_input #(
    parameter int NUM_COLS        = 7,
    parameter int NUM_ROWS        = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          sw,
    input  logic                btn,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                move_ready,
    output logic                move_valid,
    output logic [2:0]          move_col,
    output logic                move_player,
    output logic                invalid_pulse,
    output logic [5:0]          move_count,
    output logic                board_full
);

    localparam int             MAX_MOVES = NUM_COLS * NUM_ROWS;
    localparam logic [5:0]     MAX_COUNT = 6'(MAX_MOVES);
    localparam int             CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        OFFER    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-stage synchronizers for the asynchronous button and switches
    // ------------------------------------------------------------------
    logic       btn_meta_reg;
    logic       btn_sync_reg;
    logic [3:0] sw_meta_reg;
    logic [3:0] sw_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
            sw_meta_reg  <= 4'd0;
            sw_sync_reg  <= 4'd0;
        end else begin
            btn_meta_reg <= btn;
            btn_sync_reg <= btn_meta_reg;
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt_reg;
    logic [CNT_W-1:0] db_cnt_next;
    logic             db_level_reg;
    logic             db_level_next;
    logic             db_prev_reg;
    logic             press_evt;

    always_comb begin
        db_cnt_next   = db_cnt_reg;
        db_level_next = db_level_reg;
        if (btn_sync_reg == db_level_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == CNT_LAST) begin
            db_level_next = ~db_level_reg;
            db_cnt_next   = '0;
        end else begin
            db_cnt_next = db_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
            db_prev_reg  <= 1'b0;
        end else begin
            db_cnt_reg   <= db_cnt_next;
            db_level_reg <= db_level_next;
            db_prev_reg  <= db_level_reg;
        end
    end

    assign press_evt = db_level_reg & ~db_prev_reg;

    // ------------------------------------------------------------------
    // Move validation on the latched column
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [3:0]           col_reg;
    logic [NUM_COLS-1:0]  col_hit;
    logic                 col_oob;
    logic                 reject;

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_hit
        assign col_hit[gi] = (col_reg == 4'(gi)) && col_full[gi];
    end

    assign col_oob = (int'(col_reg) >= NUM_COLS);
    assign reject  = board_full | col_oob | (|col_hit);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    logic       move_valid_reg;
    logic [2:0] move_col_reg;
    logic       move_player_reg;
    logic       invalid_pulse_reg;
    logic [5:0] move_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            col_reg           <= 4'd0;
            move_valid_reg    <= 1'b0;
            move_col_reg      <= 3'd0;
            move_player_reg   <= 1'b0;
            invalid_pulse_reg <= 1'b0;
            move_count_reg    <= 6'd0;
        end else begin
            invalid_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press_evt) begin
                        col_reg   <= sw_sync_reg;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        invalid_pulse_reg <= 1'b1;
                        state_reg         <= WAIT_REL;
                    end else begin
                        move_valid_reg <= 1'b1;
                        move_col_reg   <= col_reg[2:0];
                        state_reg      <= OFFER;
                    end
                end
                OFFER: begin
                    // The offer is committed: later col_full changes cannot withdraw it
                    if (move_ready) begin
                        move_valid_reg  <= 1'b0;
                        move_player_reg <= ~move_player_reg;
                        if (move_count_reg != MAX_COUNT) begin
                            move_count_reg <= move_count_reg + 6'd1;
                        end
                        state_reg <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!db_level_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign move_valid    = move_valid_reg;
    assign move_col      = move_col_reg;
    assign move_player   = move_player_reg;
    assign invalid_pulse = invalid_pulse_reg;
    assign move_count    = move_count_reg;
    assign board_full    = (move_count_reg == MAX_COUNT);

endmodule

// File: doc/connect4_move_input.md
Name: connect4_move_input

Overview:
- Input-side counterpart of the board/LED output path: turns the raw column switches and drop button into validated, handshaked move requests for the gameboard logic.
- Synchronizes and debounces the button, latches the 4-bit column on a debounced press, and rejects out-of-range or full columns.
- Offers each accepted move with valid/ready, then alternates the player and counts moves up to a full board.

Parameters:
- NUM_COLS, 7, number of playable columns; legal column indices are 0..NUM_COLS-1.
- NUM_ROWS, 6, rows per column; the board is full after NUM_COLS*NUM_ROWS accepted moves.
- DEBOUNCE_CYCLES, 4, consecutive stable synced cycles needed to change the debounced button level (hardware builds override this, e.g. 500000).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  4  raw column switches {Switch_3..Switch_0}; asynchronous to clk.
- btn  input  1  raw drop button (BTN_EAST); asynchronous and bouncing.
- col_full  input  NUM_COLS  bit i=1 means column i has no free cell; driven by the board logic.
- move_ready  input  1  downstream accepts the offered move this cycle.
- move_valid  output  1  a move is being offered.
- move_col  output  3  offered column index; stable while move_valid=1.
- move_player  output  1  0 = player 1, 1 = player 2; stable while move_valid=1.
- invalid_pulse  output  1  one-cycle pulse when a press is rejected.
- move_count  output  6  number of accepted moves; saturates at NUM_COLS*NUM_ROWS.
- board_full  output  1  high when move_count equals NUM_COLS*NUM_ROWS.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM goes to IDLE, synchronizer and debounce state are 0, and the debounce counter clears. Reset during OFFER drops move_valid immediately and discards the move.
- Synchronizers: btn and sw each pass through 2 flip-flops. Only the synced values are used downstream.
- Debounce counter:
  - While synced btn differs from the debounced level, the counter increments each cycle; it clears whenever they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press event: the debounced level goes 0->1, detected against a registered copy of the debounced level.
- FSM states: IDLE, CHECK, OFFER, WAIT_REL.
  - IDLE: on a press event, latch synced sw into col_reg and go to CHECK. Other cycles stay in IDLE.
  - CHECK (exactly 1 cycle): the move is rejected if board_full=1, or col_reg >= NUM_COLS, or col_full[col_reg]=1. col_full is sampled in this cycle only.
    - Rejected: invalid_pulse=1 for the next cycle only, then go to WAIT_REL.
    - Accepted: set move_valid=1, move_col=col_reg[2:0], then go to OFFER.
  - OFFER: hold move_valid, move_col and move_player unchanged until move_ready=1.
    - On the cycle with move_valid&move_ready: next cycle move_valid=0, move_player toggles, move_count increments (saturating), state goes to WAIT_REL.
    - col_full changes during OFFER do not withdraw the offer.
  - WAIT_REL: stay until the debounced level is 0, then go to IDLE. Presses never queue, so one physical press yields at most one move.
- Latency: move_valid rises 2 cycles after the debounced level rises, which is 2 + DEBOUNCE_CYCLES + 2 cycles after a clean raw btn edge.
- move_ready while move_valid=0 is ignored.
- board_full is combinational from move_count. Once set, every press yields invalid_pulse and move_count stays at 42.
- sw changes after the latch do not affect the offered move.

Test Plan:
- Reset with rst_n=0, then release; hold btn=0 for 20 cycles -> all outputs 0, move_count=0.
- sw=3, clean btn press, move_ready=1 -> move_valid rises 8 cycles after the raw edge with move_col=3, move_player=0. Next cycle: move_valid=0, move_player=1, move_count=1.
- btn glitch of 3 cycles, then btn held for 10 cycles with move_ready=0, sw changed to 5 during OFFER -> exactly one offer, move_col=3 held stable until move_ready=1. The press is not repeated while held.
- sw=7 press -> one-cycle invalid_pulse, no move_valid. sw=2 with col_full[2]=1 -> invalid_pulse, move_count unchanged.
- 42 accepted moves over legal columns -> board_full=1, move_count=42. A 43rd press -> invalid_pulse, move_count stays 42.
- rst_n pulled low mid-OFFER -> move_valid=0 asynchronously. After release, FSM is in IDLE, move_player=0, move_count=0.
